clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Parametrised, multi-channel clock-enable/clock generator driven from the 100 MHz board clock.
- Each channel has a runtime-programmable divisor, an output mode and an enable.
- Each channel produces a single-cycle tick strobe plus a divided clock-like level output.
- Replaces per-design fixed dividers. Channel reset defaults reproduce the legacy 500 Hz slow clock.

Parameters:
- NUM_CH, 4: number of independent channels (1..16).
- CNT_W, 20: counter and divisor width in bits.
- DEF_DIV, 100000: divisor loaded into every channel at reset. Must be less than 2^CNT_W.
- CH_W, 2: width of cfg_ch. Must be at least clog2(NUM_CH), minimum 1.

Ports:
- clk100MHz  in  1  system clock, 100 MHz
- rst  in  1  reset, synchronous, active-high
- cfg_valid  in  1  configuration write request
- cfg_ch  in  CH_W  target channel of the configuration write
- cfg_div  in  CNT_W  new divisor (period in clk cycles)
- cfg_mode  in  1  new mode: 0 = toggle, 1 = duty
- cfg_ready  out  1  configuration write can be accepted this cycle
- ch_en  in  NUM_CH  per-channel run enable
- sync_restart  in  1  restart all channels in phase
- tick  out  NUM_CH  one-cycle strobe per channel period
- clk_out  out  NUM_CH  divided level output per channel

Behaviour:
- All outputs are registered except cfg_ready.
- rst (highest priority), per channel:
  - cnt = 0, div = DEF_DIV, mode = 0, pending = 0.
  - tick = 0, clk_out = 0.
- Divisor rule: cfg_div = 0 is stored as 1. The effective period is div cycles.
- Counting (ch_en high, no restart):
  - cnt increments each cycle.
  - When cnt == div-1: cnt wraps to 0 and tick is high in the following cycle, the boundary cycle B.
  - With ch_en first sampled high at edge E, ticks appear in cycles E+div, E+2·div, and so on.
  - div = 1 gives tick high every cycle.
- clk_out, mode 0: inverts in each boundary cycle B, so period = 2·div, 50% duty.
- clk_out, mode 1: high for cycles B .. B+floor(div/2)-1, low otherwise, so period = div.
  - div = 1 in mode 1: clk_out stays 0.
- ch_en low:
  - cnt held at 0; tick and clk_out forced to 0 from the next cycle.
  - Re-enable restarts timing as above.
- sync_restart high:
  - In the next cycle, all channels have cnt = 0, tick = 0, clk_out = 0.
  - Any pending configuration is applied.
  - Overrides a terminal count in the same cycle.
  - Enabled channels then count in phase; first tick is div cycles after the last restart cycle.
- Configuration handshake:
  - cfg_ready = NOT pending[cfg_ch] (combinational).
  - A write is accepted when cfg_valid & cfg_ready.
  - On accept, cfg_div and cfg_mode go into the channel's shadow register and pending is set.
  - Shadow values are copied to div/mode, and pending cleared, at the channel's next terminal count, or on the next cycle if the channel is disabled or restarting.
  - This guarantees no truncated or stretched period.
  - The new div governs the period starting at the following B.
  - If cfg_ch >= NUM_CH, cfg_ready = 1 and the write is accepted and discarded.
  - cfg_valid held while cfg_ready is low simply waits; there is no overwrite.
- Width: cnt compare is CNT_W bits unsigned. No overflow is possible since cnt < div.
- Reset mid-operation: rst discards pending writes and restores defaults, regardless of other inputs.

Test Plan:
- Reset defaults: rst 3 cycles, ch_en=0001, hold 400000 cycles.
  - Required: ch0 tick every 100000 cycles; clk_out[0] toggles every 100000 cycles (500 Hz).
  - Required: ch1-3 outputs stay 0.
- Program and mode 0: write ch2 div=4 mode=0 while disabled, then ch_en[2]=1 at edge E.
  - Required: ticks at E+4, E+8, E+12; clk_out[2] pattern 0000 1111 0000.
- Mode 1 odd divisor: ch1 div=5 mode=1.
  - Required: clk_out[1] high 2 cycles, low 3 cycles, repeating; tick coincides with each rising edge.
- Shadow timing: ch0 div=8 running; write div=3 at cnt=2.
  - Required: cfg_ready low until the cnt=7 wrap; remaining period stays 8 cycles; subsequent ticks every 3.
  - Required: a second write held during pending is accepted only after the wrap.
- Restart and edge cases:
  - ch0 div=6, ch1 div=9, asserting sync_restart at an arbitrary cycle → both ticks coincide at restart+18.
  - cfg_div=0 → tick every cycle.
  - cfg_ch=7 with NUM_CH=4 → accepted, no channel changes.
  - rst asserted mid-pending → pending cleared, div=DEF_DIV.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel tick strobe and divided level output.
// Divisor/mode writes go through a shadow register so a running period is never truncated or stretched.
module clk_div_multi #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 20,
    parameter int unsigned DEF_DIV = 100000,
    parameter int unsigned CH_W    = 2
) (
    input  logic              clk100MHz,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic              cfg_ready,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DIV_ONE = CNT_W'(1);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] ch_sel;
    logic [NUM_CH-1:0] wr;

    // Channel decode; an out-of-range cfg_ch selects nothing, so it is always ready and discarded.
    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_sel[i] = (cfg_ch == CH_W'(i));
        end
    end

    assign cfg_ready = ~|(ch_sel & pending);
    assign wr        = ch_sel & {NUM_CH{cfg_valid & cfg_ready}};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic [CNT_W-1:0] div, div_nxt;
        logic [CNT_W-1:0] shd_div, shd_div_nxt;
        logic             mode, mode_nxt;
        logic             shd_mode, shd_mode_nxt;
        logic             pend, pend_nxt;
        logic             tick_q, tick_nxt;
        logic             clk_q, clk_nxt;
        logic             wrap;

        assign wrap = (cnt == div - DIV_ONE);

        // Next-state: restart/disable park the channel; otherwise count and wrap on terminal count.
        always_comb begin
            cnt_nxt      = cnt;
            div_nxt      = div;
            mode_nxt     = mode;
            shd_div_nxt  = shd_div;
            shd_mode_nxt = shd_mode;
            pend_nxt     = pend;
            tick_nxt     = 1'b0;
            clk_nxt      = clk_q;

            if (sync_restart || !ch_en[g]) begin
                cnt_nxt = '0;
                clk_nxt = 1'b0;
                if (pend) begin
                    div_nxt  = shd_div;
                    mode_nxt = shd_mode;
                    pend_nxt = 1'b0;
                end
            end else if (wrap) begin
                cnt_nxt  = '0;
                tick_nxt = 1'b1;
                if (pend) begin
                    div_nxt  = shd_div;
                    mode_nxt = shd_mode;
                    pend_nxt = 1'b0;
                end
                // The boundary cycle already belongs to the new period, so use the new settings.
                clk_nxt = mode_nxt ? (div_nxt > DIV_ONE) : ~clk_q;
            end else begin
                cnt_nxt = cnt + DIV_ONE;
                if (mode) begin
                    clk_nxt = clk_q && (cnt_nxt < (div >> 1));
                end
            end

            // Writes are only accepted while not pending, so they never collide with an apply.
            if (wr[g]) begin
                shd_div_nxt  = (cfg_div == '0) ? DIV_ONE : cfg_div;
                shd_mode_nxt = cfg_mode;
                pend_nxt     = 1'b1;
            end
        end

        always_ff @(posedge clk100MHz) begin
            if (rst) begin
                cnt      <= '0;
                div      <= DIV_RST;
                mode     <= 1'b0;
                shd_div  <= DIV_RST;
                shd_mode <= 1'b0;
                pend     <= 1'b0;
                tick_q   <= 1'b0;
                clk_q    <= 1'b0;
            end else begin
                cnt      <= cnt_nxt;
                div      <= div_nxt;
                mode     <= mode_nxt;
                shd_div  <= shd_div_nxt;
                shd_mode <= shd_mode_nxt;
                pend     <= pend_nxt;
                tick_q   <= tick_nxt;
                clk_q    <= clk_nxt;
            end
        end

        assign pending[g] = pend;
        assign tick[g]    = tick_q;
        assign clk_out[g] = clk_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus random traffic, checked every cycle
// against an event-schedule model (absolute edge numbers of each channel's next boundary).
module tb_clk_div_multi;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned CNT_W   = 20;
    localparam int unsigned DEF_DIV = 50;
    localparam int unsigned CH_W    = 3;

    logic              clk100MHz = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_mode;
    logic              cfg_ready;
    logic [NUM_CH-1:0] ch_en;
    logic              sync_restart;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_out;

    clk_div_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DEF_DIV(DEF_DIV),
        .CH_W   (CH_W)
    ) dut (
        .clk100MHz   (clk100MHz),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_mode    (cfg_mode),
        .cfg_ready   (cfg_ready),
        .ch_en       (ch_en),
        .sync_restart(sync_restart),
        .tick        (tick),
        .clk_out     (clk_out)
    );

    always #5 clk100MHz = ~clk100MHz;

    int tests = 0;
    int fails = 0;
    longint n = 0;
    bit last_accept;

    // Reference model: each channel schedules its next boundary as an absolute edge number.
    int unsigned m_div   [NUM_CH];
    int unsigned m_sdiv  [NUM_CH];
    bit          m_mode  [NUM_CH];
    bit          m_smode [NUM_CH];
    bit          m_pend  [NUM_CH];
    bit          m_active[NUM_CH];
    bit          m_hlast [NUM_CH];
    longint      m_next  [NUM_CH];
    longint      m_last  [NUM_CH];
    bit          exp_tick[NUM_CH];
    bit          exp_clk [NUM_CH];

    task automatic model_apply(input int c);
        if (m_pend[c]) begin
            m_div[c]  = m_sdiv[c];
            m_mode[c] = m_smode[c];
            m_pend[c] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit acc);
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                m_div[c] = DEF_DIV; m_mode[c] = 1'b0; m_pend[c] = 1'b0;
                m_active[c] = 1'b0; m_hlast[c] = 1'b0;
                exp_tick[c] = 1'b0; exp_clk[c] = 1'b0;
                continue;
            end
            if (sync_restart || !ch_en[c]) begin
                m_active[c] = 1'b0; m_hlast[c] = 1'b0;
                exp_tick[c] = 1'b0; exp_clk[c] = 1'b0;
                model_apply(c);
            end else begin
                if (!m_active[c]) begin
                    m_active[c] = 1'b1;
                    m_hlast[c]  = 1'b0;
                    m_next[c]   = n + longint'(m_div[c]) - 1;
                end
                if (n == m_next[c]) begin
                    model_apply(c);
                    exp_tick[c] = 1'b1;
                    m_last[c]   = n;
                    m_hlast[c]  = 1'b1;
                    m_next[c]   = n + longint'(m_div[c]);
                    exp_clk[c]  = m_mode[c] ? (m_div[c] >= 2) : !exp_clk[c];
                end else begin
                    exp_tick[c] = 1'b0;
                    if (m_mode[c])
                        exp_clk[c] = m_hlast[c] && ((n - m_last[c]) < longint'(m_div[c] / 2));
                end
            end
            if (acc && c == int'(cfg_ch)) begin
                m_sdiv[c]  = (cfg_div == '0) ? 1 : int'(cfg_div);
                m_smode[c] = cfg_mode;
                m_pend[c]  = 1'b1;
            end
        end
    endtask

    // One clock: check cfg_ready, advance model, then check outputs just after the edge.
    task automatic cycle();
        bit ready_m;
        #1;
        ready_m = 1'b1;
        for (int c = 0; c < NUM_CH; c++)
            if (c == int'(cfg_ch)) ready_m = !m_pend[c];
        tests++;
        assert (cfg_ready === ready_m) else begin
            fails++;
            $error("FAIL cfg_ready n=%0d got %b exp %b", n + 1, cfg_ready, ready_m);
        end
        last_accept = cfg_valid && ready_m;
        n++;
        model_edge(last_accept);
        @(posedge clk100MHz);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            tests++;
            assert (tick[c] === exp_tick[c]) else begin
                fails++;
                $error("FAIL tick[%0d] n=%0d got %b exp %b", c, n, tick[c], exp_tick[c]);
            end
            tests++;
            assert (clk_out[c] === exp_clk[c]) else begin
                fails++;
                $error("FAIL clk_out[%0d] n=%0d got %b exp %b", c, n, clk_out[c], exp_clk[c]);
            end
        end
    endtask

    task automatic run(input int cycles);
        repeat (cycles) cycle();
    endtask

    // Holds a write until accepted; waits reports the number of cycles cfg_valid was high.
    task automatic cfg_write(input int ch, input int dv, input bit md, output int waits);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(dv);
        cfg_mode  = md;
        waits     = 0;
        do begin
            cycle();
            waits++;
        end while (!last_accept && waits < 200);
        tests++;
        assert (last_accept) else begin
            fails++;
            $error("FAIL cfg_write_timeout ch=%0d got waits=%0d exp accept", ch, waits);
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        int w;
        int guard;
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
        ch_en = '0; sync_restart = 1'b0;
        run(3);
        rst = 1'b0;

        // Defaults: channel 0 alone, DEF_DIV period, toggle mode.
        ch_en = 4'b0001;
        run(160);

        // Channel 2 programmed while disabled, then enabled.
        cfg_write(2, 4, 1'b0, w);
        run(1);
        ch_en = 4'b0101;
        run(20);

        // Channel 1 odd divisor in duty mode.
        cfg_write(1, 5, 1'b1, w);
        run(1);
        ch_en = 4'b0111;
        run(25);

        // Shadow timing on running channel 0.
        cfg_write(0, 8, 1'b0, w);
        run(70);
        guard = 0;
        while (!(m_hlast[0] && (n - m_last[0]) == 2) && guard < 50) begin
            cycle();
            guard++;
        end
        tests++;
        assert (guard < 50) else begin
            fails++;
            $error("FAIL cnt2_search got guard=%0d exp <50", guard);
        end
        cfg_write(0, 3, 1'b0, w);
        tests++;
        assert (w == 1) else begin
            fails++;
            $error("FAIL first_write_waits got %0d exp 1", w);
        end
        cfg_write(0, 5, 1'b0, w);
        tests++;
        assert (w == 6) else begin
            fails++;
            $error("FAIL held_write_waits got %0d exp 6", w);
        end
        run(30);

        // In-phase restart of div 6 and div 9.
        cfg_write(0, 6, 1'b0, w);
        cfg_write(1, 9, 1'b0, w);
        run(30);
        run(int'($urandom_range(0, 10)));
        sync_restart = 1'b1;
        cycle();
        sync_restart = 1'b0;
        run(18);
        tests++;
        assert (tick[1:0] === 2'b11) else begin
            fails++;
            $error("FAIL restart_coincide got %b exp 11", tick[1:0]);
        end

        // Zero divisor behaves as 1.
        cfg_write(3, 0, 1'b0, w);
        run(1);
        ch_en = 4'b1111;
        run(10);

        // Out-of-range channel is accepted and discarded.
        cfg_write(7, 3, 1'b1, w);
        tests++;
        assert (w == 1) else begin
            fails++;
            $error("FAIL out_of_range_waits got %0d exp 1", w);
        end
        run(20);

        // Reset while a write is pending.
        cfg_write(0, 2, 1'b0, w);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        ch_en  = 4'b0001;
        cfg_ch = '0;
        #1;
        tests++;
        assert (cfg_ready === 1'b1) else begin
            fails++;
            $error("FAIL ready_after_rst got %b exp 1", cfg_ready);
        end
        run(110);

        // Random traffic.
        ch_en = 4'b1111;
        for (int k = 0; k < 600; k++) begin
            cfg_valid    = ($urandom_range(0, 3) == 0);
            cfg_ch       = CH_W'($urandom_range(0, 5));
            cfg_div      = CNT_W'($urandom_range(0, 12));
            cfg_mode     = 1'($urandom_range(0, 1));
            sync_restart = ($urandom_range(0, 60) == 0);
            rst          = ($urandom_range(0, 250) == 0);
            if ($urandom_range(0, 30) == 0) ch_en = NUM_CH'($urandom);
            cycle();
        end
        cfg_valid = 1'b0; sync_restart = 1'b0; rst = 1'b0;
        run(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
